execute_stage: RTL

//  Execute/writeback stage of the single-cycle core, directly downstream of instruction decode.

---
 rtl/execute_stage.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/execute_stage.sv
// execute_stage: execute/writeback stage holding the 16x32 register file, NZCV flags, ALU, branch resolve and data-memory port.
// Latency: ALU, branch and store resolve in one cycle; loads take two (stall in the first, writeback in the second).
// Backpressure: clk_en=0 freezes all state; stall holds fetch during a load. EXEC_ALIGN_CHECK_EN enables alignment/special checks with sticky err_bits.
module execute_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic        clk_en,
    input  logic [31:0] pc,
    input  logic        branch,
    input  logic        loadStore,
    input  logic        dataRegisterImm,
    input  logic        specialEncoding,
    input  logic        setFlags,
    input  logic [2:0]  aluFunction,
    input  logic        regWrite,
    input  logic [3:0]  out_destRegister,
    input  logic [3:0]  out_sourceFirstReg,
    input  logic [3:0]  out_sourceSecReg,
    input  logic [15:0] out_imm,
    input  logic [3:0]  branchInstruction,
    input  logic [31:0] dataIn,
    output logic        writeFlag,
    output logic [31:0] dataOut,
    output logic [31:0] addressIn,
    output logic        branch_taken,
    output logic [31:0] branch_target,
    output logic        stall,
    output logic [3:0]  flags,
    output logic [1:0]  err_bits
);
    localparam int NUM_REGS = 16;
    localparam int DATA_W   = 32;

    typedef enum logic [0:0] {S_EXEC, S_LOAD_WB} state_t;

    state_t              state_q, state_d;
    logic [DATA_W-1:0]   regs_q [NUM_REGS];
    logic [DATA_W-1:0]   regs_d [NUM_REGS];
    logic [3:0]          flags_q, flags_d;
    logic [DATA_W-1:0]   ld_addr_q, ld_addr_d;
    logic [3:0]          ld_dest_q, ld_dest_d;

    logic [DATA_W-1:0]   a_op, b_op, mem_addr, alu_res;
    logic [DATA_W:0]     sum33, dif33;
    logic                alu_c, alu_v, cond_ok;
    logic                in_exec, is_load, is_store;
    logic                load_go, store_go, alu_wr, flag_wr;
    logic                align_fault, spec_fault;

    // Operand fetch and memory address; register reads see pre-edge contents
    always_comb begin
        a_op     = regs_q[out_sourceFirstReg];
        b_op     = dataRegisterImm ? {16'h0000, out_imm} : regs_q[out_sourceSecReg];
        mem_addr = a_op + {16'h0000, out_imm};
    end

    // ALU with NZCV carry/overflow generation; C and V hold for logical ops
    always_comb begin
        sum33   = {1'b0, a_op} + {1'b0, b_op};
        dif33   = {1'b0, a_op} + {1'b0, ~b_op} + 33'd1;
        alu_res = '0;
        alu_c   = flags_q[1];
        alu_v   = flags_q[0];
        case (aluFunction)
            3'b000: begin
                alu_res = sum33[DATA_W-1:0];
                alu_c   = sum33[DATA_W];
                alu_v   = (a_op[31] == b_op[31]) && (alu_res[31] != a_op[31]);
            end
            3'b001: begin
                alu_res = dif33[DATA_W-1:0];
                alu_c   = dif33[DATA_W];
                alu_v   = (a_op[31] != b_op[31]) && (alu_res[31] != a_op[31]);
            end
            3'b010:  alu_res = a_op & b_op;
            3'b011:  alu_res = a_op | b_op;
            3'b100:  alu_res = a_op ^ b_op;
            3'b101:  alu_res = a_op << b_op[4:0];
            3'b110:  alu_res = a_op >> b_op[4:0];
            default: alu_res = b_op;
        endcase
    end

    // Branch condition on the flags as they stand before this cycle's update
    always_comb begin
        case (branchInstruction)
            4'h0:    cond_ok = flags_q[2];
            4'h1:    cond_ok = !flags_q[2];
            4'h2:    cond_ok = flags_q[1];
            4'h3:    cond_ok = !flags_q[1];
            4'h4:    cond_ok = flags_q[3];
            4'h5:    cond_ok = !flags_q[3];
            4'h6:    cond_ok = flags_q[0];
            4'h7:    cond_ok = !flags_q[0];
            4'h8:    cond_ok = flags_q[1] && !flags_q[2];
            4'h9:    cond_ok = !flags_q[1] || flags_q[2];
            4'hA:    cond_ok = (flags_q[3] == flags_q[0]);
            4'hB:    cond_ok = (flags_q[3] != flags_q[0]);
            4'hC:    cond_ok = !flags_q[2] && (flags_q[3] == flags_q[0]);
            4'hD:    cond_ok = flags_q[2] || (flags_q[3] != flags_q[0]);
            4'hE:    cond_ok = 1'b1;
            default: cond_ok = 1'b0;
        endcase
    end

`ifdef EXEC_ALIGN_CHECK_EN
    logic [1:0] err_q, err_d;

    assign align_fault = loadStore && (mem_addr[1:0] != 2'b00);
    assign spec_fault  = specialEncoding;
    assign err_bits    = err_q;

    // Sticky error capture; only decoded instructions in S_EXEC can raise errors
    always_comb begin
        err_d = err_q;
        if (in_exec && align_fault) err_d[0] = 1'b1;
        if (in_exec && spec_fault)  err_d[1] = 1'b1;
    end

    // Error register, cleared only by reset
    always_ff @(posedge clk) begin
        if (rst)         err_q <= 2'b00;
        else if (clk_en) err_q <= err_d;
    end
`else
    assign align_fault = 1'b0;
    assign spec_fault  = 1'b0;
    assign err_bits    = 2'b00;
`endif

    // Decode qualification; in S_LOAD_WB the decode inputs are ignored entirely
    always_comb begin
        in_exec  = (state_q == S_EXEC);
        is_load  = loadStore && regWrite;
        is_store = loadStore && !regWrite;
        load_go  = in_exec && is_load  && !align_fault && !spec_fault;
        store_go = in_exec && is_store && !align_fault && !spec_fault;
        alu_wr   = in_exec && regWrite && !loadStore && !branch && !specialEncoding;
        flag_wr  = in_exec && setFlags && !loadStore && !branch && !spec_fault;
    end

    // Output drive; strobes are masked during reset and write strobe also by clk_en
    always_comb begin
        writeFlag     = store_go && clk_en && !rst;
        stall         = load_go && !rst;
        branch_taken  = in_exec && branch && cond_ok && !rst;
        branch_target = pc + {{14{out_imm[15]}}, out_imm, 2'b00};
        addressIn     = in_exec ? mem_addr : ld_addr_q;
        dataOut       = regs_q[out_destRegister];
        flags         = flags_q;
    end

    // Next-state: load writeback has priority because decode is ignored in S_LOAD_WB
    always_comb begin
        for (int i = 0; i < NUM_REGS; i++) regs_d[i] = regs_q[i];
        state_d   = S_EXEC;
        flags_d   = flags_q;
        ld_addr_d = ld_addr_q;
        ld_dest_d = ld_dest_q;
        if (!in_exec) begin
            regs_d[ld_dest_q] = dataIn;
        end else begin
            if (alu_wr)  regs_d[out_destRegister] = alu_res;
            if (flag_wr) flags_d = {alu_res[31], (alu_res == '0), alu_c, alu_v};
            if (load_go) begin
                state_d   = S_LOAD_WB;
                ld_addr_d = mem_addr;
                ld_dest_d = out_destRegister;
            end
        end
    end

    // State registers; reset abandons any pending load
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_EXEC;
            flags_q   <= '0;
            ld_addr_q <= '0;
            ld_dest_q <= '0;
            for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
        end else if (clk_en) begin
            state_q   <= state_d;
            flags_q   <= flags_d;
            ld_addr_q <= ld_addr_d;
            ld_dest_q <= ld_dest_d;
            for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= regs_d[i];
        end
    end
endmodule
